// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline run-control block and the debug unit.
// State codes are part of the debug-visible interface, so their values are fixed.
package pipeline_ctrl_pkg;

  localparam int unsigned NB_STATE         = 3;
  localparam int unsigned NB_COUNT_DEFAULT = 32;

  typedef enum logic [NB_STATE-1:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StPause  = 3'd3,
    StHalted = 3'd4
  } state_e;

  // Stages advance only in these states.
  function automatic logic state_enables_pipe(state_e st);
    return (st == StRun) || (st == StStep);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/step/stop/halt sequencer for the CPU pipeline, plus cycle and retired-instruction
// counters. The pipeline enable is decoded from the registered state only.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_COUNT = pipeline_ctrl_pkg::NB_COUNT_DEFAULT,
  parameter int unsigned NB_STATE = pipeline_ctrl_pkg::NB_STATE
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cmd_run,
  input  logic                i_cmd_step,
  input  logic                i_cmd_stop,
  input  logic                i_cmd_clear,
  input  logic                i_halt_wb,
  input  logic                i_wb_valid,
  output logic                o_pipe_en,
  output logic                o_pipe_clr,
  output logic [NB_STATE-1:0] o_state,
  output logic                o_done,
  output logic [NB_COUNT-1:0] o_cycle_count,
  output logic [NB_COUNT-1:0] o_retired_count
);

  state_e state_q;
  state_e state_d;
  logic   pipe_en;
  logic   pipe_clr_q;

  assign pipe_en = state_enables_pipe(state_q);

  always_comb begin
    state_d = state_q;
    if (i_cmd_clear) begin
      state_d = StIdle;
    end else if (pipe_en && i_halt_wb) begin
      // HALT in WB retires this cycle, then the pipeline freezes.
      state_d = StHalted;
    end else begin
      case (state_q)
        StIdle, StPause: begin
          // A stop here is a no-op but still masks lower-priority commands.
          if (i_cmd_stop) begin
            state_d = state_q;
          end else if (i_cmd_step) begin
            state_d = StStep;
          end else if (i_cmd_run) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (i_cmd_stop) begin
            state_d = StPause;
          end
        end
        StStep:   state_d = StPause;
        StHalted: state_d = StHalted;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      pipe_clr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pipe_clr_q <= i_cmd_clear;
    end
  end

  sat_counter #(
    .WIDTH (NB_COUNT)
  ) u_cycle_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_cmd_clear),
    .inc   (pipe_en),
    .count (o_cycle_count)
  );

  sat_counter #(
    .WIDTH (NB_COUNT)
  ) u_retired_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (i_cmd_clear),
    .inc   (pipe_en && i_wb_valid),
    .count (o_retired_count)
  );

  assign o_pipe_en  = pipe_en;
  assign o_pipe_clr = pipe_clr_q;
  assign o_state    = NB_STATE'(state_q);
  assign o_done     = (state_q == StHalted);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default 32-bit instance and a 4-bit counter
// instance share all stimulus; outputs are sampled on the falling clock edge.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd_run = 1'b0, cmd_step = 1'b0, cmd_stop = 1'b0, cmd_clear = 1'b0;
  logic halt_wb = 1'b0, wb_valid = 1'b0;

  logic        pipe_en, pipe_clr, done;
  logic [2:0]  state;
  logic [31:0] cyc, ret;
  logic        pipe_en4, pipe_clr4, done4;
  logic [2:0]  state4;
  logic [3:0]  cyc4, ret4;

  int checks = 0;
  int errors = 0;
  int en_seen;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_cmd_run (cmd_run), .i_cmd_step (cmd_step), .i_cmd_stop (cmd_stop),
    .i_cmd_clear (cmd_clear), .i_halt_wb (halt_wb), .i_wb_valid (wb_valid),
    .o_pipe_en (pipe_en), .o_pipe_clr (pipe_clr), .o_state (state), .o_done (done),
    .o_cycle_count (cyc), .o_retired_count (ret)
  );

  pipeline_ctrl #(.NB_COUNT (4)) dut4 (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_cmd_run (cmd_run), .i_cmd_step (cmd_step), .i_cmd_stop (cmd_stop),
    .i_cmd_clear (cmd_clear), .i_halt_wb (halt_wb), .i_wb_valid (wb_valid),
    .o_pipe_en (pipe_en4), .o_pipe_clr (pipe_clr4), .o_state (state4), .o_done (done4),
    .o_cycle_count (cyc4), .o_retired_count (ret4)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("rst_pipe_clr", {31'd0, pipe_clr}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_ret", ret, 32'd0);
    chk("rst_cyc4", {28'd0, cyc4}, 32'd0);
    rst_n = 1'b1;
    wb_valid = 1'b1;

    // Run for exactly 10 enabled cycles, then stop
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    chk("run_state", {29'd0, state}, 32'd1);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (pipe_en) en_seen++;
      if (i == 9) cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
    end
    chk("run_en_cycles", en_seen, 32'd10);
    chk("stop_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("stop_state", {29'd0, state}, 32'd3);
    chk("run_cyc", cyc, 32'd10);
    chk("run_ret", ret, 32'd10);
    tick();
    chk("pause_hold_en", {31'd0, pipe_en}, 32'd0);

    // Three single steps, four cycles apart
    for (int k = 0; k < 3; k++) begin
      cmd_step = 1'b1; tick(); cmd_step = 1'b0;
      chk("step_state", {29'd0, state}, 32'd2);
      chk("step_en", {31'd0, pipe_en}, 32'd1);
      tick();
      chk("step_back_pause", {29'd0, state}, 32'd3);
      chk("step_en_low", {31'd0, pipe_en}, 32'd0);
      tick(); tick();
    end
    chk("step_cyc", cyc, 32'd13);
    chk("step_ret", ret, 32'd13);

    // Clear, then run with HALT reaching WB on enabled cycle 7
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    chk("clr_state", {29'd0, state}, 32'd0);
    chk("clr_pulse", {31'd0, pipe_clr}, 32'd1);
    chk("clr_cyc", cyc, 32'd0);
    tick();
    chk("clr_pulse_end", {31'd0, pipe_clr}, 32'd0);
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    en_seen = 0;
    for (int i = 1; i <= 7; i++) begin
      if (pipe_en) en_seen++;
      if (i == 7) halt_wb = 1'b1;
      tick();
      halt_wb = 1'b0;
    end
    chk("halt_en_cycles", en_seen, 32'd7);
    chk("halt_en_low", {31'd0, pipe_en}, 32'd0);
    chk("halt_state", {29'd0, state}, 32'd4);
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_cyc", cyc, 32'd7);
    chk("halt_ret", ret, 32'd7);
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    chk("halted_run_ign", {29'd0, state}, 32'd4);
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    chk("halted_step_ign", {29'd0, state}, 32'd4);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    chk("halted_stop_ign", {29'd0, state}, 32'd4);
    chk("halted_cyc", cyc, 32'd7);
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    chk("halt_clr_state", {29'd0, state}, 32'd0);
    chk("halt_clr_pulse", {31'd0, pipe_clr}, 32'd1);
    chk("halt_clr_done", {31'd0, done}, 32'd0);
    chk("halt_clr_ret", ret, 32'd0);

    // Command priority
    cmd_clear = 1'b1; cmd_stop = 1'b1; cmd_step = 1'b1; cmd_run = 1'b1;
    tick();
    cmd_clear = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0; cmd_run = 1'b0;
    chk("all_cmd_state", {29'd0, state}, 32'd0);
    chk("all_cmd_en", {31'd0, pipe_en}, 32'd0);
    tick();
    chk("all_cmd_en2", {31'd0, pipe_en}, 32'd0);
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    chk("idle_step", {29'd0, state}, 32'd2);
    tick();
    chk("idle_step_pause", {29'd0, state}, 32'd3);
    halt_wb = 1'b1; tick(); halt_wb = 1'b0;
    chk("pause_halt_ign", {29'd0, state}, 32'd3);
    cmd_stop = 1'b1; cmd_run = 1'b1; tick(); cmd_stop = 1'b0; cmd_run = 1'b0;
    chk("stop_masks_run", {29'd0, state}, 32'd3);
    cmd_step = 1'b1; cmd_run = 1'b1; tick(); cmd_step = 1'b0; cmd_run = 1'b0;
    chk("step_over_run", {29'd0, state}, 32'd2);
    tick();
    chk("step_over_run_pause", {29'd0, state}, 32'd3);
    chk("prio_cyc", cyc, 32'd2);

    // HALT during a single step
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    halt_wb = 1'b1; tick(); halt_wb = 1'b0;
    chk("step_halt_state", {29'd0, state}, 32'd4);
    chk("step_halt_done", {31'd0, done}, 32'd1);
    chk("step_halt_cyc", cyc, 32'd3);

    // Saturation on the 4-bit instance
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    cmd_step = 1'b1; tick(); cmd_step = 1'b0;
    chk("run_step_ign", {29'd0, state}, 32'd1);
    for (int i = 0; i < 19; i++) tick();
    chk("sat_cyc32", cyc, 32'd20);
    chk("sat_cyc4", {28'd0, cyc4}, 32'd15);
    chk("sat_ret4", {28'd0, ret4}, 32'd15);
    chk("sat_state4", {29'd0, state4}, 32'd1);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("arst_en", {31'd0, pipe_en}, 32'd0);
    chk("arst_en4", {31'd0, pipe_en4}, 32'd0);
    chk("arst_state", {29'd0, state}, 32'd0);
    chk("arst_cyc", cyc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    chk("post_rst_run", {29'd0, state}, 32'd1);
    chk("post_rst_en", {31'd0, pipe_en}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
